// File: rtl/instruction_set_pkg.sv
// Shared core definitions: control_unit state, word size and instruction format.
// Also holds the fetch-FSM state type and the HALT instruction that a fetch fault injects.
package instruction_set;

    localparam int unsigned WORD_SIZE   = 16;
    localparam int unsigned INSTR_W     = 40;
    localparam int unsigned INSTR_BYTES = 5;
    localparam int unsigned OPCODE_W    = 8;

    // control_unit state; WRITEBACK and FETCH are never active together
    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } STATE_T;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_DONE = 2'd2
    } FETCH_STATE_T;

    // Opcode lives in the top byte of the instruction word
    localparam logic [OPCODE_W-1:0] OP_HALT    = 8'hFF;
    localparam logic [INSTR_W-1:0]  HALT_INSTR = {OP_HALT, {(INSTR_W-OPCODE_W){1'b0}}};

endpackage

// File: rtl/instr_fetch_unit_timeout.sv
// fetch_timeout_counter: counts enabled cycles since the last clear.
// Ports: clk, reset (async high), clear (restart count), enable (count this cycle),
//        expired (combinational: this enabled cycle is the TIMEOUT_CYCLES-th without a clear).
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Count the current enabled cycle too, so expiry fires on the TIMEOUT_CYCLES-th edge
    assign expired = enable && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && !expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC and fetches each 40-bit instruction as five big-endian
// byte reads from instruction memory, presenting the assembled word stably to control_unit.
// Ports: clk, reset (async high); current_state/next_pc from control_unit; pc, instruction,
//        fetch_busy (combinational), fetch_fault (sticky) to the core;
//        imem_req/imem_addr out, imem_rdata/imem_valid in (memory handshake).
module instr_fetch_unit
    import instruction_set::*;
#(
    parameter int unsigned IMEM_ADDR_W    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  STATE_T                 current_state,
    input  logic [WORD_SIZE-1:0]   next_pc,
    output logic [WORD_SIZE-1:0]   pc,
    output logic [INSTR_W-1:0]     instruction,
    output logic                   fetch_busy,
    output logic                   fetch_fault,
    output logic                   imem_req,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [7:0]             imem_rdata,
    input  logic                   imem_valid
);

    localparam int unsigned BIDX_W = $clog2(INSTR_BYTES);
    localparam int unsigned ASM_W  = INSTR_W - 8;

    FETCH_STATE_T r_state;
    FETCH_STATE_T w_state_nxt;

    logic [WORD_SIZE-1:0]   r_pc;
    logic [INSTR_W-1:0]     r_instr;
    logic [ASM_W-1:0]       r_asm;
    logic [BIDX_W-1:0]      r_byte_idx;
    logic                   r_req;
    logic [IMEM_ADDR_W-1:0] r_addr;
    logic                   r_fault;

    logic                   w_issue;
    logic                   w_beat;
    logic                   w_last;
    logic                   w_timeout;
    logic                   w_expired;
    logic [IMEM_ADDR_W-1:0] w_base;

    // Byte address of the instruction; wraps silently
    assign w_base = IMEM_ADDR_W'(32'(r_pc) * 32'(INSTR_BYTES));

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_issue || w_beat),
        .enable (r_state == F_REQ),
        .expired(w_expired)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= F_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            F_IDLE: if (current_state == FETCH && !r_fault) w_state_nxt = F_REQ;
            F_REQ:  if (w_last || w_timeout)                w_state_nxt = F_DONE;
            F_DONE: if (current_state != FETCH)             w_state_nxt = F_IDLE;
            default:                                        w_state_nxt = F_IDLE;
        endcase
    end

    // Output/strobe decode; a valid beat takes priority over a same-cycle timeout
    always_comb begin
        w_issue    = (r_state == F_IDLE) && (current_state == FETCH) && !r_fault;
        w_beat     = (r_state == F_REQ) && imem_valid;
        w_last     = w_beat && (r_byte_idx == BIDX_W'(INSTR_BYTES - 1));
        w_timeout  = (r_state == F_REQ) && !imem_valid && w_expired;
        fetch_busy = (current_state == FETCH) && (r_state != F_DONE) && !r_fault;
    end

    // PC, request and assembly datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= '0;
            r_instr    <= '0;
            r_asm      <= '0;
            r_byte_idx <= '0;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_fault    <= 1'b0;
        end else begin
            if (current_state == WRITEBACK) begin
                r_pc <= next_pc;
            end
            if (w_issue) begin
                r_byte_idx <= '0;
                r_req      <= 1'b1;
                r_addr     <= w_base;
            end
            if (w_beat) begin
                r_asm <= {r_asm[ASM_W-9:0], imem_rdata};
                if (w_last) begin
                    // Whole word lands in one edge so control_unit never sees a partial value
                    r_instr <= {r_asm, imem_rdata};
                    r_req   <= 1'b0;
                end else begin
                    r_byte_idx <= r_byte_idx + BIDX_W'(1);
                    r_addr     <= r_addr + IMEM_ADDR_W'(1);
                end
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
                r_instr <= HALT_INSTR;
                r_req   <= 1'b0;
            end
        end
    end

    assign pc          = r_pc;
    assign instruction = r_instr;
    assign fetch_fault = r_fault;
    assign imem_req    = r_req;
    assign imem_addr   = r_addr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a byte-memory responder model.
module tb_instr_fetch_unit;
    import instruction_set::*;

    localparam int unsigned AW = 16;
    localparam int MEMSZ = 1 << AW;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    STATE_T               cs = DECODE;
    logic [WORD_SIZE-1:0] next_pc = '0;
    logic [WORD_SIZE-1:0] pc;
    logic [INSTR_W-1:0]   instruction;
    logic                 busy, fault, req;
    logic [AW-1:0]        addr;
    logic [7:0]           rdata = 8'h00;
    logic                 valid = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.IMEM_ADDR_W(AW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .current_state(cs), .next_pc(next_pc),
        .pc(pc), .instruction(instruction), .fetch_busy(busy), .fetch_fault(fault),
        .imem_req(req), .imem_addr(addr), .imem_rdata(rdata), .imem_valid(valid)
    );

    logic [7:0] mem [0:MEMSZ-1];
    int  dly [5];
    bit  spur = 1'b0;
    int  n_cmp = 0;
    int  n_err = 0;

    logic [AW-1:0]      addr_q [$];
    logic [INSTR_W-1:0] instr_q [$];
    bit                 fault_q [$];
    logic [INSTR_W-1:0] last_instr = '0;
    logic [WORD_SIZE-1:0] exp_pc = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory responder: answers byte i after dly[i] idle cycles; optional stray valids when idle
    int wcnt = 0;
    int bidx = 0;
    always @(posedge clk or posedge reset) begin
        #1;
        valid = 1'b0;
        if (reset) begin
            wcnt = 0;
            bidx = 0;
        end else if (req) begin
            if (bidx < 5 && wcnt >= dly[bidx]) begin
                valid = 1'b1;
                rdata = mem[addr];
                wcnt  = 0;
                bidx++;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
            bidx = 0;
            if (spur && $urandom_range(0, 1) == 1) begin
                valid = 1'b1;
                rdata = 8'($urandom);
            end
        end
    end

    // Monitor: checks beat addresses, completed words, and instruction stability
    bit prev_busy = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
        end else begin
            if (req && valid) begin
                if (addr_q.size() == 0) chk("unexpected_beat", 64'(addr), 64'hFFFF_FFFF);
                else chk("imem_addr", 64'(addr), 64'(addr_q.pop_front()));
            end
            if (prev_busy && !busy && cs == FETCH) begin
                if (instr_q.size() == 0) begin
                    chk("unexpected_done", 64'(instruction), 64'hFFFF_FFFF_FFFF);
                end else begin
                    last_instr = instr_q.pop_front();
                    chk("fetch_fault", 64'(fault), 64'(fault_q.pop_front()));
                end
            end
            chk("instruction", 64'(instruction), 64'(last_instr));
            prev_busy = busy;
        end
    end

    task automatic flush();
        addr_q.delete();
        instr_q.delete();
        fault_q.delete();
        last_instr = '0;
        exp_pc = '0;
    endtask

    task automatic do_reset();
        cs = DECODE;
        reset = 1'b1;
        flush();
        #12;
        @(negedge clk);
        chk("rst_pc", 64'(pc), 0);
        chk("rst_instr", 64'(instruction), 0);
        chk("rst_req", 64'(req), 0);
        chk("rst_addr", 64'(addr), 0);
        chk("rst_fault", 64'(fault), 0);
        chk("rst_busy", 64'(busy), 0);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic set_pc(input logic [WORD_SIZE-1:0] v);
        cs = WRITEBACK;
        next_pc = v;
        @(posedge clk); #1;
        cs = DECODE;
        exp_pc = v;
        @(negedge clk);
        chk("pc_update", 64'(pc), 64'(exp_pc));
        @(posedge clk); #1;
    endtask

    // Reference: word is mem[base..base+4] big-endian; a byte waiting >=16 cycles faults
    task automatic push_expect(output int busy_exp);
        int base, k, a;
        logic [INSTR_W-1:0] w;
        base = (int'(exp_pc) * int'(INSTR_BYTES)) % MEMSZ;
        k = 5;
        for (int i = 4; i >= 0; i--) if (dly[i] >= 16) k = i;
        busy_exp = 1;
        w = '0;
        for (int i = 0; i < 5; i++) begin
            a = (base + i) % MEMSZ;
            w = {w[INSTR_W-9:0], mem[a]};
            if (i < k) begin
                addr_q.push_back(16'(a));
                busy_exp += dly[i] + 1;
            end
        end
        if (k < 5) begin
            busy_exp += 16;
            instr_q.push_back(HALT_INSTR);
            fault_q.push_back(1'b1);
        end else begin
            instr_q.push_back(w);
            fault_q.push_back(1'b0);
        end
    endtask

    task automatic fetch_run();
        int busy_exp, cnt;
        bit done;
        push_expect(busy_exp);
        cs = FETCH;
        cnt = 0;
        done = 1'b0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
            else cnt++;
        end
        chk("fetch_completes", 64'(done), 1);
        chk("busy_cycles", 64'(cnt), 64'(busy_exp));
        chk("pc_hold", 64'(pc), 64'(exp_pc));
        @(posedge clk); #1;
        cs = DECODE;
        @(posedge clk); #1;
        chk("beats_consumed", 64'(addr_q.size()), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44; mem[4] = 8'h55;
        for (int i = 0; i < 5; i++) dly[i] = 0;

        // Basic fetch at pc 0 with single-cycle memory
        do_reset();
        fetch_run();
        chk("first_word", 64'(instruction), 64'h11_2233_4455);

        // PC update and address wrap at the top of memory (0x3333*5 = 0xFFFF)
        set_pc(16'd3);
        fetch_run();
        set_pc(16'h3333);
        fetch_run();

        // Slow memory: three wait cycles per byte
        for (int i = 0; i < 5; i++) dly[i] = 3;
        set_pc(16'd7);
        fetch_run();

        // Randomized fetches with stray valids while idle, plus the no-fault 15-cycle boundary
        spur = 1'b1;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 5; i++) dly[i] = $urandom_range(0, 4);
            if (n == 9) dly[$urandom_range(0, 4)] = 15;
            set_pc(16'($urandom));
            fetch_run();
        end
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk("idle_no_req", 64'(req), 0);
        end
        spur = 1'b0;

        // Async reset after two bytes of a fetch from pc 3
        for (int i = 0; i < 5; i++) dly[i] = 2;
        set_pc(16'd3);
        begin
            int be;
            push_expect(be);
        end
        cs = FETCH;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk); #1;
            if (addr_q.size() == 3) ok = 1'b1;
        end
        chk("two_beats_seen", 64'(ok), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_req", 64'(req), 0);
        chk("async_rst_pc", 64'(pc), 0);
        chk("async_rst_instr", 64'(instruction), 0);
        cs = DECODE;
        flush();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) dly[i] = 0;
        fetch_run();
        chk("restart_word", 64'(instruction), 64'h11_2233_4455);

        // Timeout on byte 2, then a later fetch must not issue a request
        dly[2] = 20;
        set_pc(16'd9);
        fetch_run();
        chk("fault_set", 64'(fault), 1);
        chk("fault_halt", 64'(instruction), 64'(HALT_INSTR));
        cs = FETCH;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("post_fault_req", 64'(req), 0);
            chk("post_fault_busy", 64'(busy), 0);
        end
        @(posedge clk); #1;
        cs = DECODE;
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
